// File: rtl/byte_packer.sv
// Byte-to-word packer: gathers up to four bytes from a valid/ready stream into a 32-bit word.
// A packet-end marker closes a short word early; the unused lanes carry PAD.
module byte_packer #(
  parameter logic [7:0] PAD       = 8'h00,
  parameter bit         MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_count,
  output logic        out_last
);

  localparam logic [31:0] AsmPad = {4{PAD}};

  logic [1:0]  idx_q, idx_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;
  logic [2:0]  count_q, count_d;
  logic        last_q, last_d;

  logic        in_fire, out_fire, complete;
  logic [1:0]  lane;
  logic [31:0] asm_ins;

  always_comb begin
    in_ready = !valid_q || out_ready;
    in_fire  = in_valid && in_ready;
    out_fire = valid_q && out_ready;
    complete = in_fire && ((idx_q == 2'd3) || in_last);

    // Physical lane of the current byte slot; lane 3 is bits [31:24].
    lane    = MSB_FIRST ? (2'd3 - idx_q) : idx_q;
    asm_ins = asm_q;
    asm_ins[{lane, 3'b000} +: 8] = in_data;
  end

  always_comb begin
    idx_d   = idx_q;
    asm_d   = asm_q;
    word_d  = word_q;
    valid_d = valid_q;
    count_d = count_q;
    last_d  = last_q;

    if (complete) begin
      // Lanes past idx still hold PAD because asm restarts from AsmPad after every word.
      word_d  = asm_ins;
      count_d = {1'b0, idx_q} + 3'd1;
      last_d  = in_last;
      valid_d = 1'b1;
      idx_d   = 2'd0;
      asm_d   = AsmPad;
    end else begin
      if (in_fire) begin
        asm_d = asm_ins;
        idx_d = idx_q + 2'd1;
      end
      if (out_fire) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= 2'd0;
      asm_q   <= AsmPad;
      word_q  <= 32'h0;
      valid_q <= 1'b0;
      count_q <= 3'd0;
      last_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign out_word  = word_q;
  assign out_valid = valid_q;
  assign out_count = count_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_byte_packer.sv
// Bench for byte_packer: two instances (MSB-first/PAD 00 and LSB-first/PAD FF) share one stream;
// a byte-list reference model feeds a scoreboard that a separate monitor drains.
module tb_byte_packer;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_last, out_ready;
  logic [7:0] in_data;

  logic        in_ready_m, out_valid_m, out_last_m;
  logic [31:0] out_word_m;
  logic [2:0]  out_count_m;
  logic        in_ready_l, out_valid_l, out_last_l;
  logic [31:0] out_word_l;
  logic [2:0]  out_count_l;

  always #5 clk = ~clk;

  byte_packer dut_msb (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready_m),
    .out_word  (out_word_m),
    .out_valid (out_valid_m),
    .out_ready (out_ready),
    .out_count (out_count_m),
    .out_last  (out_last_m)
  );

  byte_packer #(
    .PAD       (8'hFF),
    .MSB_FIRST (1'b0)
  ) dut_lsb (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready_l),
    .out_word  (out_word_l),
    .out_valid (out_valid_l),
    .out_ready (out_ready),
    .out_count (out_count_l),
    .out_last  (out_last_l)
  );

  typedef struct {
    logic [31:0] w_msb;
    logic [31:0] w_lsb;
    logic [2:0]  cnt;
    logic        last;
  } exp_t;

  int errors = 0;
  int checks = 0;

  logic [7:0] cur[$];
  exp_t       exp_q[$];
  bit         exp_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Word as the packing rule defines it: byte i of the packet goes to slot i, slots past n are PAD.
  function automatic exp_t build(input logic [7:0] b[$], input logic last);
    exp_t e;
    int   n;
    n       = b.size();
    e.w_msb = 32'h0;
    e.w_lsb = 32'h0;
    for (int i = 0; i < 4; i++) begin
      e.w_msb[31-8*i -: 8] = (i < n) ? b[i] : 8'h00;
      e.w_lsb[8*i +: 8]    = (i < n) ? b[i] : 8'hFF;
    end
    e.cnt  = 3'(n);
    e.last = last;
    return e;
  endfunction

  // Reference model: decides acceptance from its own notion of a pending output word.
  always @(negedge clk) begin
    if (reset) begin
      cur.delete();
      exp_q.delete();
      exp_valid = 1'b0;
    end else begin
      bit rdy;
      rdy = !exp_valid || out_ready;
      check("out_valid", 32'(out_valid_m), 32'(exp_valid));
      check("out_valid_lsb", 32'(out_valid_l), 32'(exp_valid));
      check("in_ready", 32'(in_ready_m), 32'(rdy));
      check("in_ready_lsb", 32'(in_ready_l), 32'(rdy));
      if (exp_valid && out_ready) exp_valid = 1'b0;
      if (in_valid && rdy) begin
        cur.push_back(in_data);
        if (cur.size() == 4 || in_last) begin
          exp_q.push_back(build(cur, in_last));
          cur.delete();
          exp_valid = 1'b1;
        end
      end
    end
  end

  // Monitor: the presented word must match the scoreboard head for as long as it is held.
  always @(negedge clk) begin
    if (!reset && out_valid_m) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h expected no word", out_word_m);
      end else begin
        exp_t e;
        e = exp_q[0];
        check("word_msb", out_word_m, e.w_msb);
        check("word_lsb", out_word_l, e.w_lsb);
        check("count_msb", 32'(out_count_m), 32'(e.cnt));
        check("count_lsb", 32'(out_count_l), 32'(e.cnt));
        check("last_msb", 32'(out_last_m), 32'(e.last));
        check("last_lsb", 32'(out_last_l), 32'(e.last));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check_zero(input string tag);
    @(negedge clk);
    check({tag, "_word"}, out_word_m, 32'h0);
    check({tag, "_word_lsb"}, out_word_l, 32'h0);
    check({tag, "_count"}, 32'(out_count_m), 32'h0);
    check({tag, "_last"}, 32'(out_last_m), 32'h0);
    check({tag, "_valid"}, 32'(out_valid_m), 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle_check_zero("post_reset");

    // Full word, both lane orders.
    drive(1, 8'h12, 0);
    drive(1, 8'h34, 0);
    drive(1, 8'h56, 0);
    drive(1, 8'h78, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("full_msb", out_word_m, 32'h12345678);
    check("full_lsb", out_word_l, 32'h78563412);
    check("full_count", 32'(out_count_m), 32'd4);
    check("full_o1", 32'(out_word_m[31:24]), 32'h12);
    @(posedge clk);
    #1;

    // Short packet with PAD lanes.
    drive(1, 8'hAA, 0);
    drive(1, 8'hBB, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    check("short_msb", out_word_m, 32'hAABB0000);
    check("short_lsb", out_word_l, 32'hFFFFBBAA);
    check("short_count", 32'(out_count_m), 32'd2);
    check("short_last", 32'(out_last_m), 32'd1);
    @(posedge clk);
    #1;

    drive(1, 8'hCC, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    check("single_lsb", out_word_l, 32'hFFFFFFCC);
    check("single_msb", out_word_m, 32'hCC000000);
    check("single_count", 32'(out_count_l), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back stream: never stalls with out_ready held high.
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      in_last  = 1'b0;
      @(negedge clk);
      check("stream_ready", 32'(in_ready_m), 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_word2", out_word_m, 32'h05060708);
    @(posedge clk);
    #1;

    // Backpressure holds the word and blocks even a fill-only byte.
    for (int i = 1; i <= 4; i++) drive(1, 8'(i), 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h05;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready_m), 32'd0);
      check("bp_word", out_word_m, 32'h01020304);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 32'(in_ready_m), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // Reset discards the partial word (05 plus DE AD).
    drive(1, 8'hDE, 0);
    drive(1, 8'hAD, 0);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_check_zero("mid_reset");
    drive(1, 8'h11, 0);
    drive(1, 8'h22, 0);
    drive(1, 8'h33, 0);
    drive(1, 8'h44, 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("after_reset_word", out_word_m, 32'h11223344);
    @(posedge clk);
    #1;

    // Randomized traffic with occasional reset.
    repeat (3000) begin
      reset     = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/byte_packer.md
Name: byte_packer

Overview:
- Upstream feeder for the 32-bit byte splitter stage.
- Accepts a byte stream over a valid/ready handshake and packs four consecutive bytes into one 32-bit word.
- A packet-end marker closes a partial word early; unfilled byte lanes are padded.
- The registered word output drives the splitter input directly, so the first accepted byte appears on the splitter's most-significant byte output (O1).

Parameters:
- PAD, 8'h00, fill value for unused byte lanes of a short (in_last-terminated) word.
- MSB_FIRST, 1, 1: first byte lands in [31:24], last in [7:0]; 0: first byte lands in [7:0], last in [31:24].

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  incoming byte.
- in_valid  input  1  in_data is valid this cycle.
- in_last  input  1  qualifies in_data as the final byte of a packet; meaningful only with in_valid.
- in_ready  output  1  packer can accept a byte this cycle.
- out_word  output  32  packed word, feeds splitter input A.
- out_valid  output  1  out_word holds an unconsumed word.
- out_ready  input  1  downstream consumes out_word this cycle.
- out_count  output  3  number of real bytes in out_word (1..4); 0 when out_valid=0 after reset.
- out_last  output  1  out_word closes a packet.

Behaviour:
- Reset (synchronous, active-high) sets: idx=0, assembly register=all PAD, out_word=32'h0, out_valid=0, out_count=0, out_last=0.
- Any partial word in progress at reset is discarded. Reset has priority over every other event in the same cycle.
- in_ready = !out_valid || out_ready. It is purely combinational from state and out_ready, and never depends on in_valid or in_last.
- in_fire = in_valid && in_ready. out_fire = out_valid && out_ready.
- Internal state: 2-bit lane index idx (0..3) and a 32-bit assembly register asm.
- FILL (no word complete): on in_fire with idx<3 and in_last=0:
  - write in_data into lane idx; lane idx is bits [31-8*idx:24-8*idx] when MSB_FIRST=1, else bits [8*idx+7:8*idx];
  - idx <= idx+1.
- COMPLETE: on in_fire with idx==3 or in_last=1:
  - out_word <= asm with lane idx replaced by in_data; lanes above idx hold PAD;
  - out_count <= idx+1, out_last <= in_last, out_valid <= 1;
  - idx <= 0, asm <= all PAD.
  - Latency: the word is visible on out_word the cycle after the byte that completes it is accepted.
- Output drain: on out_fire with no COMPLETE in the same cycle, out_valid <= 0. out_word, out_count and out_last hold their last values.
- Simultaneous out_fire and COMPLETE: the new word loads and out_valid stays 1. This gives sustained throughput of 1 byte/cycle and 1 word per 4 cycles.
- Backpressure:
  - while out_valid=1 and out_ready=0, in_ready=0 and no byte is accepted, including FILL-only bytes;
  - out_word, out_count and out_last stay stable until out_fire.
- in_last at idx==3 is a normal full word: out_count=4, out_last=1.
- in_last=1 with in_valid=0 is ignored.
- idx wraps 3->0 only through COMPLETE. There is no other wrap path.
- No error outputs. Bytes offered while in_ready=0 are not consumed; the source must hold them.

Test Plan:
- Reset, then bytes 8'h12,34,56,78 on consecutive cycles, out_ready=1 -> cycle after 8'h78: out_word=32'h12345678, out_count=4, out_last=0, out_valid=1 for exactly one cycle; splitter sees O1=8'h12, O4=8'h78.
- Bytes 8'hAA,8'hBB with in_last on 8'hBB, PAD=8'h00 -> out_word=32'hAABB0000, out_count=2, out_last=1; next word starts at lane 0.
- Stream 8'h01..8'h08 back-to-back, out_ready=1 -> in_ready constantly 1; words 32'h01020304 then 32'h05060708 on consecutive 4-cycle boundaries, no bubbles.
- out_ready=0 after first word 32'h01020304 completes, in_valid held with 8'h05 -> in_ready=0 and out_word stable for 5 cycles; raising out_ready -> 8'h05 accepted the same cycle and the word drains.
- Assert reset after 8'hDE,8'hAD accepted, then send 8'h11,22,33,44 -> out_word=32'h11223344; the partial bytes never appear; all outputs were 0 the cycle after reset.
- MSB_FIRST=0, bytes 8'h12,34,56,78 -> out_word=32'h78563412; single byte 8'hCC with in_last, PAD=8'hFF -> out_word=32'hFFFFFFCC, out_count=1.
